// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(15,11) constants, FSM state encoding and parity function
package hamming_pkg;

    localparam int W_DADO   = 11;
    localparam int W_CODIGO = 15;

    localparam int POS_P14 = 14;
    localparam int POS_P13 = 13;
    localparam int POS_P11 = 11;
    localparam int POS_P7  = 7;

    typedef enum logic {
        OCIOSO    = 1'b0,
        TRANSMITE = 1'b1
    } estado_t;

    // Returns {p14, p13, p11, p7}, even parity over the covered data bits.
    function automatic logic [3:0] calcula_paridade(input logic [W_DADO-1:0] d);
        logic p14, p13, p11, p7;
        p14 = d[10] ^ d[9] ^ d[7] ^ d[6] ^ d[4] ^ d[2] ^ d[0];
        p13 = d[10] ^ d[8] ^ d[7] ^ d[5] ^ d[4] ^ d[1] ^ d[0];
        p11 = d[9]  ^ d[8] ^ d[7] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
        p7  = d[6]  ^ d[5] ^ d[4] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
        return {p14, p13, p11, p7};
    endfunction

endpackage

// File: rtl/codifica_hamming_tx_if.sv
// rtl/codifica_hamming_tx_if.sv - word handshake into the Hamming transmitter (HAMMING_INJ_ERRO_EN adds fault injection)
interface codifica_hamming_tx_if;
    import hamming_pkg::*;

    logic [W_DADO-1:0] dado;
    logic              dado_valido;
    logic              dado_pronto;
`ifdef HAMMING_INJ_ERRO_EN
    logic              inj_erro;
    logic [3:0]        inj_pos;

    modport master (output dado, output dado_valido, output inj_erro, output inj_pos, input dado_pronto);
    modport slave  (input dado, input dado_valido, input inj_erro, input inj_pos, output dado_pronto);
`else
    modport master (output dado, output dado_valido, input dado_pronto);
    modport slave  (input dado, input dado_valido, output dado_pronto);
`endif

endinterface

// File: rtl/codifica_hamming.sv
// rtl/codifica_hamming.sv - combinational Hamming(15,11) encoder, layout shared with corrige_hamming
module codifica_hamming
    import hamming_pkg::*;
(
    input  logic [W_DADO-1:0]   dado,
    output logic [W_CODIGO-1:0] codigo
);

    logic [3:0] paridade;

    assign paridade = calcula_paridade(dado);

    assign codigo[POS_P14] = paridade[3];
    assign codigo[POS_P13] = paridade[2];
    assign codigo[12]      = dado[10];
    assign codigo[POS_P11] = paridade[1];
    assign codigo[10:8]    = dado[9:7];
    assign codigo[POS_P7]  = paridade[0];
    assign codigo[6:0]     = dado[6:0];

endmodule

// File: rtl/codifica_hamming_tx.sv
// rtl/codifica_hamming_tx.sv - Hamming(15,11) serial transmitter, MSB first; HAMMING_INJ_ERRO_EN enables bit-flip injection
module codifica_hamming_tx
    import hamming_pkg::*;
#(
    parameter int DIVISOR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    codifica_hamming_tx_if.slave  entrada,
    output logic [W_CODIGO-1:0]   codigo,
    output logic                  tx_bit,
    output logic                  tx_quadro,
    output logic                  fim
);

    localparam logic [7:0] DIV_FIM = 8'(DIVISOR - 1);
    localparam logic [3:0] BIT_FIM = 4'(W_CODIGO - 1);

    estado_t             estado;
    logic [W_CODIGO-1:0] desloca;
    logic [3:0]          cnt_bit;
    logic [7:0]          cnt_div;
    logic [W_CODIGO-1:0] codigo_limpo;
    logic [W_CODIGO-1:0] codigo_tx;

    codifica_hamming u_codifica (
        .dado   (entrada.dado),
        .codigo (codigo_limpo)
    );

`ifdef HAMMING_INJ_ERRO_EN
    // inj_pos = 15 falls outside the codeword and leaves it untouched.
    always_comb begin
        codigo_tx = codigo_limpo;
        if (entrada.inj_erro && entrada.inj_pos != 4'd15) begin
            codigo_tx[entrada.inj_pos] = ~codigo_limpo[entrada.inj_pos];
        end
    end
`else
    assign codigo_tx = codigo_limpo;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado              <= OCIOSO;
            entrada.dado_pronto <= 1'b1;
            codigo              <= '0;
            desloca             <= '0;
            tx_bit              <= 1'b0;
            tx_quadro           <= 1'b0;
            fim                 <= 1'b0;
            cnt_bit             <= '0;
            cnt_div             <= '0;
        end else begin
            fim <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (entrada.dado_valido) begin
                        codigo              <= codigo_tx;
                        desloca             <= codigo_tx;
                        tx_bit              <= codigo_tx[W_CODIGO-1];
                        tx_quadro           <= 1'b1;
                        entrada.dado_pronto <= 1'b0;
                        cnt_bit             <= '0;
                        cnt_div             <= '0;
                        estado              <= TRANSMITE;
                    end
                end
                TRANSMITE: begin
                    if (cnt_div == DIV_FIM) begin
                        cnt_div <= '0;
                        if (cnt_bit == BIT_FIM) begin
                            tx_bit              <= 1'b0;
                            tx_quadro           <= 1'b0;
                            entrada.dado_pronto <= 1'b1;
                            fim                 <= 1'b1;
                            estado              <= OCIOSO;
                        end else begin
                            desloca <= {desloca[W_CODIGO-2:0], 1'b0};
                            tx_bit  <= desloca[W_CODIGO-2];
                            cnt_bit <= cnt_bit + 4'd1;
                        end
                    end else begin
                        cnt_div <= cnt_div + 8'd1;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_codifica_hamming_tx.sv
// tb/tb_codifica_hamming_tx.sv - self-checking bench for codifica_hamming_tx at DIVISOR 1 and 3
module tb_codifica_hamming_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    codifica_hamming_tx_if b1 ();
    codifica_hamming_tx_if b3 ();

    logic [14:0] codigo1, codigo3;
    logic        tx_bit1, tx_bit3, tx_quadro1, tx_quadro3, fim1, fim3;

    codifica_hamming_tx #(.DIVISOR(1)) u1 (
        .clk(clk), .rst_n(rst_n), .entrada(b1),
        .codigo(codigo1), .tx_bit(tx_bit1), .tx_quadro(tx_quadro1), .fim(fim1)
    );

    codifica_hamming_tx #(.DIVISOR(3)) u3 (
        .clk(clk), .rst_n(rst_n), .entrada(b3),
        .codigo(codigo3), .tx_bit(tx_bit3), .tx_quadro(tx_quadro3), .fim(fim3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nome, atual, esperado);
        end
    endtask

    // Reference: place data bits, then each parity is the XOR of its covered data bits.
    function automatic logic [14:0] ref_encode(input logic [10:0] d);
        int          pos_dado [11] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 12};
        int          pos_par  [4]  = '{14, 13, 11, 7};
        logic [10:0] mascara  [4]  = '{11'b11011010101, 11'b10110110011,
                                       11'b01110001111, 11'b00001111111};
        logic [14:0] cw = '0;
        for (int i = 0; i < 11; i++) cw[pos_dado[i]] = d[i];
        for (int j = 0; j < 4; j++) cw[pos_par[j]] = ^(d & mascara[j]);
        return cw;
    endfunction

    // Nearest-codeword decoder: distance 3 code, so at most one candidate lies within one flip.
    function automatic logic [10:0] ref_decode(input logic [14:0] rx);
        for (int d = 0; d < 2048; d++) begin
            if ($countones(ref_encode(11'(d)) ^ rx) <= 1) return 11'(d);
        end
        return 11'h000;
    endfunction

    typedef struct packed {
        logic [10:0] d;
        logic [14:0] cw;
    } ent_t;

    function automatic ent_t captura(input logic [10:0] d, input logic inj, input logic [3:0] pos);
        ent_t e;
        e.d  = d;
        e.cw = ref_encode(d);
        if (inj && pos != 4'd15) e.cw[pos] = ~e.cw[pos];
        return e;
    endfunction

    ent_t fila1[$], fila3[$];
    bit   amostras1[$], amostras3[$];
    int   fims1 = 0, fims3 = 0;
    bit   fim_ant1 = 0, fim_ant3 = 0;

    task automatic fecha_quadro(input string nome, input int div, input bit s[$], input ent_t e);
        logic [14:0] rx = '0;
        bit estavel = 1'b1;
        check({nome, "_comprimento"}, s.size(), 15 * div);
        if (s.size() == 15 * div) begin
            for (int i = 0; i < 15; i++) begin
                rx[14-i] = s[i*div];
                for (int j = 1; j < div; j++) if (s[i*div+j] != s[i*div]) estavel = 1'b0;
            end
            check({nome, "_bit_estavel"}, estavel, 1);
            check({nome, "_serial"}, rx, e.cw);
            check({nome, "_decodifica"}, ref_decode(rx), e.d);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            amostras1.delete();
            fila1.delete();
            fim_ant1 = 1'b0;
        end else begin
            if (b1.dado_valido && b1.dado_pronto) begin
`ifdef HAMMING_INJ_ERRO_EN
                fila1.push_back(captura(b1.dado, b1.inj_erro, b1.inj_pos));
`else
                fila1.push_back(captura(b1.dado, 1'b0, 4'd15));
`endif
            end
            if (tx_quadro1) amostras1.push_back(tx_bit1);
            if (fim1) begin
                fims1++;
                check("fim1_um_ciclo", fim_ant1, 0);
                if (fila1.size() == 0) check("fim1_sem_transferencia", 1, 0);
                else fecha_quadro("d1", 1, amostras1, fila1.pop_front());
                amostras1.delete();
            end
            fim_ant1 = fim1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            amostras3.delete();
            fila3.delete();
            fim_ant3 = 1'b0;
        end else begin
            if (b3.dado_valido && b3.dado_pronto) fila3.push_back(captura(b3.dado, 1'b0, 4'd15));
            if (tx_quadro3) amostras3.push_back(tx_bit3);
            if (fim3) begin
                fims3++;
                check("fim3_um_ciclo", fim_ant3, 0);
                if (fila3.size() == 0) check("fim3_sem_transferencia", 1, 0);
                else fecha_quadro("d3", 3, amostras3, fila3.pop_front());
                amostras3.delete();
            end
            fim_ant3 = fim3;
        end
    end

    task automatic espera_pronto1();
        int t = 0;
        @(negedge clk);
        while (!b1.dado_pronto && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("timeout_pronto1", 0, 1);
    endtask

    task automatic envia1(input logic [10:0] d);
        espera_pronto1();
        b1.dado = d;
        b1.dado_valido = 1'b1;
        @(posedge clk);
        #1 b1.dado_valido = 1'b0;
    endtask

    task automatic espera_fim1();
        int t = 0;
        while (!fim1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("timeout_fim1", 0, 1);
    endtask

    task automatic confere_reset(input string nome);
        check({nome, "_pronto"}, b1.dado_pronto, 1);
        check({nome, "_codigo"}, codigo1, 0);
        check({nome, "_tx_bit"}, tx_bit1, 0);
        check({nome, "_tx_quadro"}, tx_quadro1, 0);
        check({nome, "_fim"}, fim1, 0);
    endtask

    typedef struct packed {
        logic [10:0] d;
        logic [14:0] cw;
    } vetor_t;

    vetor_t tabela [4];

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] a, b, d;
        int c, n, t, f;

        tabela[0] = '{11'h000, 15'h0000};
        tabela[1] = '{11'h001, 15'h6881};
        tabela[2] = '{11'h400, 15'h7000};
        tabela[3] = '{11'h7FF, 15'h7FFF};

        b1.dado = '0; b1.dado_valido = 1'b0;
        b3.dado = '0; b3.dado_valido = 1'b0;
`ifdef HAMMING_INJ_ERRO_EN
        b1.inj_erro = 1'b0; b1.inj_pos = 4'd0;
        b3.inj_erro = 1'b0; b3.inj_pos = 4'd0;
`endif

        repeat (3) @(posedge clk);
        #1 confere_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            envia1(tabela[i].d);
            check("codigo_tabela", codigo1, tabela[i].cw);
            espera_fim1();
        end

        // DIVISOR=3 frame timing.
        @(negedge clk);
        b3.dado = 11'h001;
        b3.dado_valido = 1'b1;
        @(posedge clk);
        #1 b3.dado_valido = 1'b0;
        check("codigo_div3", codigo3, 15'h6881);
        n = 0; t = 0;
        while (!fim3 && t < 300) begin
            @(negedge clk);
            if (tx_quadro3) n++;
            t++;
        end
        check("quadro_div3_ciclos", n, 45);
        @(negedge clk);
        check("fim3_apos_pulso", fim3, 0);

        // Valid held with changing data mid-frame: no capture until pronto returns.
        espera_pronto1();
        a = 11'($urandom);
        b1.dado = a;
        b1.dado_valido = 1'b1;
        @(posedge clk);
        c = 0;
        while (c < 200) begin
            #1 b1.dado = 11'($urandom);
            @(negedge clk);
            c++;
            if (b1.dado_pronto) break;
            if (codigo1 !== ref_encode(a)) check("codigo_estavel", codigo1, ref_encode(a));
            @(posedge clk);
        end
        check("intervalo_transferencias", c, 16);
        check("fim_junto_pronto", fim1, 1);
        b = b1.dado;
        @(posedge clk);
        #1 b1.dado_valido = 1'b0;
        check("codigo_segunda_palavra", codigo1, ref_encode(b));
        espera_fim1();

        // Back-to-back random stream.
        for (int k = 0; k < 100; k++) begin
            espera_pronto1();
            b1.dado = 11'($urandom);
            b1.dado_valido = 1'b1;
            @(posedge clk);
        end
        #1 b1.dado_valido = 1'b0;
        espera_fim1();

        // Reset during bit 5.
        d = 11'($urandom);
        envia1(d);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 confere_reset("reset_meio");
        f = fims1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("sem_fim_apos_reset", fims1, f);
        d = 11'($urandom);
        envia1(d);
        check("codigo_apos_reset", codigo1, ref_encode(d));
        espera_fim1();

`ifdef HAMMING_INJ_ERRO_EN
        for (int p = 0; p < 16; p++) begin
            d = 11'($urandom);
            b1.inj_erro = 1'b1;
            b1.inj_pos = 4'(p);
            envia1(d);
            if (p == 15) check("inj15_limpo", codigo1, ref_encode(d));
            else begin
                check("inj_um_bit", $countones(codigo1 ^ ref_encode(d)), 1);
                check("inj_posicao", codigo1 ^ ref_encode(d), 32'(1) << p);
            end
            check("inj_recupera", ref_decode(codigo1), d);
            espera_fim1();
        end
        b1.inj_erro = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("fila1_vazia", fila1.size(), 0);
        check("fila3_vazia", fila3.size(), 0);
        check("quadros_d3", fims3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
